// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, runtime parity/stop-bit selection and
// an internal baud divider. Frame settings are captured when a word leaves the FIFO.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DIV_WIDTH-1:0]            BAUD_DIV,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  input  logic                            STOP2,
  input  logic [DATA_WIDTH-1:0]           S_DATA,
  input  logic                            S_VALID,
  output logic                            S_READY,
  output logic                            TX_OUT,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     FIFO_COUNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  push, pop;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;

  logic [DATA_WIDTH-1:0] head;
  logic [DIV_WIDTH-1:0]  eff_div;
  logic                  bit_end;
  logic                  have_word;
  logic                  start_frame;

  assign S_READY    = (count_q != CNT_W'(FIFO_DEPTH)) && RST;
  assign push       = S_VALID && S_READY;
  assign FIFO_COUNT = count_q;
  assign TX_OUT     = tx_q;
  assign busy       = (state_q != IDLE);

  assign head      = mem[rd_ptr];
  assign eff_div   = (BAUD_DIV == '0) ? DIV_WIDTH'(1) : BAUD_DIV;
  assign bit_end   = (baud_cnt_q == '0);
  assign have_word = (count_q != '0);

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= S_DATA;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      baud_cnt_q <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, so TX_OUT tracks state_q.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    baud_cnt_d  = baud_cnt_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    par_en_d    = par_en_q;
    stop2_d     = stop2_q;
    par_bit_d   = par_bit_q;
    tx_d        = tx_q;
    pop         = 1'b0;
    start_frame = 1'b0;

    if (state_q != IDLE) begin
      if (bit_end) baud_cnt_d = div_q - DIV_WIDTH'(1);
      else         baud_cnt_d = baud_cnt_q - DIV_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (have_word) start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = BIT_W'(1);
            tx_d      = 1'b1;
          end else if (have_word) begin
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Popping a word also snapshots the line settings for the whole frame.
    if (start_frame) begin
      pop        = 1'b1;
      state_d    = START;
      tx_d       = 1'b0;
      shift_d    = head;
      div_d      = eff_div;
      baud_cnt_d = eff_div - DIV_WIDTH'(1);
      par_en_d   = PAR_EN;
      stop2_d    = STOP2;
      par_bit_d  = PAR_TYP ? ~^head : ^head;
    end
  end

endmodule
